lsu_stage: RTL and testbench
============================

Name: lsu_stage

Overview:
- Load/store unit directly downstream of the ALU.
- Consumes the ALU result as the effective address for load and store instructions.
- Runs a request/acknowledge transaction with the word-wide data memory, then returns sign- or zero-extended load data to writeback.
- Detects misaligned accesses, illegal funct3 codes and memory timeout; flags each without issuing or completing a bus cycle.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles o_mem_req waits for i_mem_ack before the access is aborted with o_fault. Minimum legal value 1.

Ports:
- i_clk  in  1  system clock, rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_valid  in  1  start access; sampled only while o_ready=1
- i_is_store  in  1  1=store, 0=load
- i_funct3  in  3  RV32I width/sign code
- i_addr  in  32  effective address (ALU o_result)
- i_store_data  in  32  rs2 value
- o_ready  out  1  unit idle, can accept i_valid
- o_done  out  1  one-cycle completion pulse
- o_load_data  out  32  extended load result; valid while o_done=1
- o_misaligned  out  1  with o_done: access misaligned
- o_fault  out  1  with o_done: illegal funct3 or timeout
- o_mem_req  out  1  memory request, held until ack
- o_mem_we  out  1  write enable
- o_mem_addr  out  32  word address, {i_addr[31:2],2'b00}
- o_mem_wdata  out  32  store data replicated into lanes
- o_mem_wstrb  out  4  byte lane strobes; 0 on loads
- i_mem_ack  in  1  memory accepted/responded this cycle
- i_mem_rdata  in  32  read word; valid when i_mem_ack=1

Behaviour:
- Reset (i_rst=1 at clock edge): state=IDLE.
  - o_ready=1.
  - o_done, o_misaligned, o_fault, o_mem_req, o_mem_we all 0.
  - o_mem_wstrb=0, o_mem_addr=0, o_mem_wdata=0, o_load_data=0.
  - Timeout counter=0.
  - Reset mid-transaction drops o_mem_req the next cycle; no o_done is produced.
- All outputs are registered. States: IDLE, REQ, DONE.
- IDLE, i_valid=1: decode and check the access.
  - Legal funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal funct3 for stores: 000 SB, 001 SH, 010 SW.
  - Anything else: go to DONE with o_fault=1; no request.
  - Misaligned = half with i_addr[0]=1, or word with i_addr[1:0]!=0. Go to DONE with o_misaligned=1; no request; o_fault=0.
  - Legal and aligned: latch funct3 and i_addr[1:0], drive o_mem_req=1, address, we, wstrb and wdata; go to REQ; o_ready=0.
- Store lanes:
  - SB: wdata = byte replicated x4; wstrb = 0001 shifted left by addr[1:0].
  - SH: wdata = {half,half}; wstrb = 0011 (addr[1]=0) or 1100 (addr[1]=1).
  - SW: wdata = data; wstrb = 1111.
- REQ: o_mem_req and all bus fields are held stable until i_mem_ack.
  - Ack: capture the extracted load data, drop req, go to DONE.
  - Load extraction: select byte by addr[1:0] or half by addr[1], then sign-extend (LB/LH) or zero-extend (LBU/LHU).
  - Stores: o_load_data=0.
  - No ack: counter increments each REQ cycle. When counter = TIMEOUT_CYCLES-1 with no ack, drop req, go to DONE with o_fault=1.
  - Ack in the same cycle as the counter limit: ack wins, no fault.
- DONE: o_done=1 for exactly one cycle with the result/flags; next cycle IDLE with o_ready=1 and flags cleared.
  - i_valid during DONE is ignored; o_ready is 0 in DONE.
- Latency: valid at edge N → req visible after N. Ack at edge N+k → o_done in cycle N+k+1. Zero-wait ack gives o_done in cycle N+2.
- Check failures: o_done in cycle N+1.
- i_mem_ack outside REQ is ignored.
- Back-to-back accesses: at most one every 3 cycles.

Test Plan:
- LB from addr 0x103, mem word 0x80_12_34_56, ack after 2 wait cycles → o_mem_addr=0x100, wstrb=0, o_load_data=0xFFFFFF80, o_done exactly once.
- LHU addr 0x202, rdata 0xBEEF1234 → o_load_data=0x0000BEEF. LH same → 0xFFFFBEEF.
- SB addr 0x301, data 0x000000AB → wdata=0xABABABAB, wstrb=0010, we=1.
- SH addr 0x302 → wstrb=1100.
- SW addr 0x300 → wstrb=1111, wdata=data.
- LW addr 0x102 → o_done+o_misaligned next cycle, o_mem_req never asserted.
- Load with funct3=011 → o_fault=1, no request.
- TIMEOUT_CYCLES=4, never ack → req high for 4 cycles then drops, o_fault with o_done.
- Assert i_rst while in REQ → next cycle req=0, o_ready=1, no o_done.
- Ack during the timeout-limit cycle → no fault, data returned.

Source files
------------

// File: rtl/lsu_stage.sv
// Load/store unit: checks width/alignment, runs one req/ack cycle with the word-wide
// data memory and returns the lane-extracted, sign/zero-extended load result.
module lsu_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   input  logic        i_is_store,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_store_data,
   output logic        o_ready,
   output logic        o_done,
   output logic [31:0] o_load_data,
   output logic        o_misaligned,
   output logic        o_fault,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_wstrb,
   input  logic        i_mem_ack,
   input  logic [31:0] i_mem_rdata
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES - 1);

   logic [1:0]    state_q, state_d;
   logic          ready_q, ready_d;
   logic          done_q, done_d;
   logic [31:0]   ld_q, ld_d;
   logic          mis_q, mis_d;
   logic          fault_q, fault_d;
   logic          req_q, req_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    wstrb_q, wstrb_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    f3_q, f3_d;
   logic [1:0]    off_q, off_d;

   logic          f3_legal;
   logic          misaligned;
   logic [3:0]    wstrb_n;
   logic [31:0]   wdata_n;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [31:0]   ld_ext;

   always_comb begin
      f3_legal = 1'b0;
      case (i_funct3)
         3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
         3'b100, 3'b101:         f3_legal = !i_is_store;
         default:                f3_legal = 1'b0;
      endcase
   end

   assign misaligned = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                       ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));

   // Store data is replicated across lanes so memory only needs the strobes.
   always_comb begin
      wstrb_n = 4'b0000;
      wdata_n = 32'h0;
      if (i_is_store) begin
         case (i_funct3[1:0])
            2'b00: begin
               wdata_n = {4{i_store_data[7:0]}};
               wstrb_n = 4'b0001 << i_addr[1:0];
            end
            2'b01: begin
               wdata_n = {2{i_store_data[15:0]}};
               wstrb_n = i_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
               wdata_n = i_store_data;
               wstrb_n = 4'b1111;
            end
         endcase
      end
   end

   assign byte_sel = 8'(i_mem_rdata >> {off_q, 3'b000});
   assign half_sel = off_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

   always_comb begin
      case (f3_q)
         3'b000:  ld_ext = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  ld_ext = {{16{half_sel[15]}}, half_sel};
         3'b100:  ld_ext = {24'h0, byte_sel};
         3'b101:  ld_ext = {16'h0, half_sel};
         default: ld_ext = i_mem_rdata;
      endcase
   end

   always_comb begin
      state_d = state_q;
      ready_d = ready_q;
      done_d  = 1'b0;
      ld_d    = ld_q;
      mis_d   = mis_q;
      fault_d = fault_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      cnt_d   = cnt_q;
      f3_d    = f3_q;
      off_d   = off_q;
      case (state_q)
         S_IDLE: begin
            if (i_valid) begin
               ready_d = 1'b0;
               ld_d    = 32'h0;
               mis_d   = 1'b0;
               fault_d = 1'b0;
               if (!f3_legal) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  fault_d = 1'b1;
               end else if (misaligned) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  mis_d   = 1'b1;
               end else begin
                  state_d = S_REQ;
                  req_d   = 1'b1;
                  we_d    = i_is_store;
                  addr_d  = {i_addr[31:2], 2'b00};
                  wdata_d = wdata_n;
                  wstrb_d = wstrb_n;
                  f3_d    = i_funct3;
                  off_d   = i_addr[1:0];
                  cnt_d   = '0;
               end
            end
         end
         S_REQ: begin
            // An ack on the limit cycle still completes normally.
            if (i_mem_ack) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               req_d   = 1'b0;
               we_d    = 1'b0;
               wstrb_d = 4'b0000;
               ld_d    = we_q ? 32'h0 : ld_ext;
            end else if (cnt_q == CNT_LIMIT) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               req_d   = 1'b0;
               we_d    = 1'b0;
               wstrb_d = 4'b0000;
               fault_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
            mis_d   = 1'b0;
            fault_d = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         ld_q    <= 32'h0;
         mis_q   <= 1'b0;
         fault_q <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         wstrb_q <= 4'b0000;
         cnt_q   <= '0;
         f3_q    <= 3'b000;
         off_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         ld_q    <= ld_d;
         mis_q   <= mis_d;
         fault_q <= fault_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         cnt_q   <= cnt_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
      end
   end

   assign o_ready      = ready_q;
   assign o_done       = done_q;
   assign o_load_data  = ld_q;
   assign o_misaligned = mis_q;
   assign o_fault      = fault_q;
   assign o_mem_req    = req_q;
   assign o_mem_we     = we_q;
   assign o_mem_addr   = addr_q;
   assign o_mem_wdata  = wdata_q;
   assign o_mem_wstrb  = wstrb_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Scoreboard bench for lsu_stage: a driver queues expected results, a negedge
// monitor checks bus fields during requests and results on each o_done pulse.
module tb_lsu_stage;

   typedef struct {
      bit          rst;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      bit          chk_wdata;
      logic [31:0] ld;
      logic        mis;
      logic        flt;
      int          reqc;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_valid = 1'b0;
   logic        i_is_store = 1'b0;
   logic [2:0]  i_funct3 = 3'b000;
   logic [31:0] i_addr = 32'h0;
   logic [31:0] i_store_data = 32'h0;
   logic        i_mem_ack = 1'b0;
   logic [31:0] i_mem_rdata = 32'h0;
   logic        o_ready, o_done, o_misaligned, o_fault;
   logic        o_mem_req, o_mem_we;
   logic [31:0] o_load_data, o_mem_addr, o_mem_wdata;
   logic [3:0]  o_mem_wstrb;

   exp_t q[$];
   bit   stim_done = 1'b0;
   int   n_cmp = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   lsu_stage #(.TIMEOUT_CYCLES(4)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_is_store(i_is_store),
      .i_funct3(i_funct3), .i_addr(i_addr), .i_store_data(i_store_data),
      .o_ready(o_ready), .o_done(o_done), .o_load_data(o_load_data),
      .o_misaligned(o_misaligned), .o_fault(o_fault), .o_mem_req(o_mem_req),
      .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
      .o_mem_wstrb(o_mem_wstrb), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // w = wait cycles before ack (-1: never ack); ex_reqc = expected cycles with o_mem_req high.
   task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd, input int w,
                      input logic [3:0] ex_strb, input logic [31:0] ex_wdata,
                      input logic [31:0] ex_ld, input logic ex_mis, input logic ex_flt,
                      input int ex_reqc);
      exp_t e;
      int   n;
      int   guard;
      e.rst = 1'b0;
      e.addr = {a[31:2], 2'b00};
      e.we = st;
      e.wstrb = ex_strb;
      e.wdata = ex_wdata;
      e.chk_wdata = st;
      e.ld = ex_ld;
      e.mis = ex_mis;
      e.flt = ex_flt;
      e.reqc = ex_reqc;
      e.lat = (ex_reqc == 0) ? 1 : ex_reqc + 1;
      q.push_back(e);
      i_valid = 1'b1;
      i_is_store = st;
      i_funct3 = f3;
      i_addr = a;
      i_store_data = wd;
      tick();
      i_valid = 1'b0;
      n = 0;
      guard = 0;
      while (!o_done) begin
         if (guard > 50) begin
            $display("FAIL done_timeout: got no o_done expected o_done within 50 cycles");
            $fatal(1, "o_done never arrived");
         end
         i_mem_ack = o_mem_req && (w >= 0) && (n == w);
         i_mem_rdata = i_mem_ack ? rd : 32'h0;
         if (o_mem_req) n++;
         tick();
         guard++;
      end
      // Noise during DONE: must be ignored.
      i_mem_ack = 1'b1;
      i_valid = 1'b1;
      i_is_store = 1'b0;
      i_funct3 = 3'b010;
      i_addr = 32'h0;
      tick();
      i_mem_ack = 1'b0;
      i_valid = 1'b0;
   endtask

   task automatic push_rst(input logic [31:0] a);
      exp_t e;
      e.rst = 1'b1;
      e.addr = a;
      e.we = 1'b0;
      e.wstrb = 4'b0000;
      e.wdata = 32'h0;
      e.chk_wdata = 1'b0;
      e.ld = 32'h0;
      e.mis = 1'b0;
      e.flt = 1'b0;
      e.reqc = 0;
      e.lat = 0;
      q.push_back(e);
   endtask

   initial begin
      push_rst(32'h0);
      repeat (3) tick();
      i_rst = 1'b0;
      tick();
      //  st  f3      addr         wdata         rdata         w   strb     ex_wdata      ex_ld         mis   flt   reqc
      run(0, 3'b000, 32'h103, 32'h0,        32'h80123456, 2,  4'b0000, 32'h0,        32'hFFFFFF80, 1'b0, 1'b0, 3);
      run(0, 3'b101, 32'h202, 32'h0,        32'hBEEF1234, 0,  4'b0000, 32'h0,        32'h0000BEEF, 1'b0, 1'b0, 1);
      run(0, 3'b001, 32'h202, 32'h0,        32'hBEEF1234, 1,  4'b0000, 32'h0,        32'hFFFFBEEF, 1'b0, 1'b0, 2);
      run(0, 3'b100, 32'h102, 32'h0,        32'h11228833, 0,  4'b0000, 32'h0,        32'h00000022, 1'b0, 1'b0, 1);
      run(0, 3'b000, 32'h101, 32'h0,        32'h000085FF, 0,  4'b0000, 32'h0,        32'hFFFFFF85, 1'b0, 1'b0, 1);
      run(0, 3'b001, 32'h200, 32'h0,        32'h12348001, 0,  4'b0000, 32'h0,        32'hFFFF8001, 1'b0, 1'b0, 1);
      run(0, 3'b010, 32'h10C, 32'h0,        32'h76543210, 0,  4'b0000, 32'h0,        32'h76543210, 1'b0, 1'b0, 1);
      run(1, 3'b000, 32'h301, 32'h000000AB, 32'h0,        0,  4'b0010, 32'hABABABAB, 32'h0,        1'b0, 1'b0, 1);
      run(1, 3'b000, 32'h300, 32'h12345678, 32'hFFFFFFFF, 1,  4'b0001, 32'h78787878, 32'h0,        1'b0, 1'b0, 2);
      run(1, 3'b001, 32'h302, 32'h1234CDEF, 32'h0,        0,  4'b1100, 32'hCDEFCDEF, 32'h0,        1'b0, 1'b0, 1);
      run(1, 3'b001, 32'h300, 32'hAAAA5555, 32'h0,        0,  4'b0011, 32'h55555555, 32'h0,        1'b0, 1'b0, 1);
      run(1, 3'b010, 32'h300, 32'hDEADBEEF, 32'h0,        0,  4'b1111, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1);
      run(0, 3'b010, 32'h102, 32'h0,        32'h0,        -1, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b0, 0);
      run(1, 3'b001, 32'h301, 32'h0,        32'h0,        -1, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b0, 0);
      run(0, 3'b101, 32'h101, 32'h0,        32'h0,        -1, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b0, 0);
      run(0, 3'b011, 32'h100, 32'h0,        32'h0,        -1, 4'b0000, 32'h0,        32'h0,        1'b0, 1'b1, 0);
      run(1, 3'b100, 32'h300, 32'h0,        32'h0,        -1, 4'b0000, 32'h0,        32'h0,        1'b0, 1'b1, 0);
      run(0, 3'b110, 32'h103, 32'h0,        32'h0,        -1, 4'b0000, 32'h0,        32'h0,        1'b0, 1'b1, 0);
      run(0, 3'b010, 32'h400, 32'h0,        32'h0,        -1, 4'b0000, 32'h0,        32'h0,        1'b0, 1'b1, 4);
      run(0, 3'b010, 32'h404, 32'h0,        32'hCAFEF00D, 3,  4'b0000, 32'h0,        32'hCAFEF00D, 1'b0, 1'b0, 4);
      // Reset while the request is outstanding.
      push_rst(32'h500);
      i_valid = 1'b1;
      i_is_store = 1'b0;
      i_funct3 = 3'b010;
      i_addr = 32'h500;
      tick();
      i_valid = 1'b0;
      repeat (2) tick();
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      tick();
      run(0, 3'b000, 32'h002, 32'h0,        32'h007F0000, 0,  4'b0000, 32'h0,        32'h0000007F, 1'b0, 1'b0, 1);
      repeat (3) tick();
      stim_done = 1'b1;
   end

   initial begin
      exp_t e;
      int   req_cycles = 0;
      int   lat = 0;
      int   txn = 0;
      bit   prev_done = 1'b0;
      bit   ready_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (i_rst) begin
            if (q.size() > 0 && q[0].rst) begin
               e = q.pop_front();
               chk("rst_ready", o_ready, 32'd1);
               chk("rst_done", o_done, 32'd0);
               chk("rst_req", o_mem_req, 32'd0);
               chk("rst_we", o_mem_we, 32'd0);
               chk("rst_wstrb", o_mem_wstrb, 32'd0);
               chk("rst_addr", o_mem_addr, 32'd0);
               chk("rst_wdata", o_mem_wdata, 32'd0);
               chk("rst_load", o_load_data, 32'd0);
               chk("rst_flags", {o_misaligned, o_fault}, 32'd0);
               $display("txn %0d: reset check", txn);
               txn++;
            end
            req_cycles = 0;
            lat = 0;
            prev_done = 1'b0;
         end else begin
            if (i_valid && ready_prev) lat = 1;
            else if (lat > 0) lat++;
            if (prev_done) begin
               chk("done_single", o_done, 32'd0);
               chk("ready_after_done", o_ready, 32'd1);
               chk("flags_cleared", {o_misaligned, o_fault}, 32'd0);
            end
            if (o_mem_req) begin
               req_cycles++;
               chk("ready_in_req", o_ready, 32'd0);
               if (q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected_req: got o_mem_req=1 expected no request");
               end else begin
                  chk("mem_addr", o_mem_addr, q[0].addr);
                  chk("mem_we", o_mem_we, q[0].we);
                  chk("mem_wstrb", o_mem_wstrb, q[0].wstrb);
                  if (q[0].chk_wdata) chk("mem_wdata", o_mem_wdata, q[0].wdata);
               end
            end
            if (o_done) begin
               if (q.size() == 0 || q[0].rst) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected_done: got o_done=1 expected no completion");
               end else begin
                  e = q.pop_front();
                  chk("load_data", o_load_data, e.ld);
                  chk("misaligned", o_misaligned, e.mis);
                  chk("fault", o_fault, e.flt);
                  chk("req_cycles", req_cycles, e.reqc);
                  chk("latency", lat, e.lat);
                  chk("ready_in_done", o_ready, 32'd0);
                  $display("txn %0d: addr=%h we=%0d ld=%h mis=%0d flt=%0d reqc=%0d lat=%0d",
                           txn, e.addr, e.we, o_load_data, o_misaligned, o_fault, req_cycles, lat);
                  txn++;
               end
               req_cycles = 0;
               lat = 0;
            end
            prev_done = o_done;
         end
         ready_prev = o_ready;
         if (stim_done) begin
            chk("queue_empty", 32'(q.size()), 32'd0);
            $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
            $finish;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish before 100000");
      $fatal(1, "watchdog expired");
   end

endmodule
